// File: rtl/lcd_text_if.sv
// Host-side buffer/refresh port and LCD pin bundle for lcd_text_engine.
// master = board logic / bench, slave = the engine.
interface lcd_text_if;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [5:0] wr_col;
    logic [7:0] wr_char;
    logic       refresh_req;
    logic       init_done;
    logic       busy;
    logic       lcd_on;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    modport master (
        output wr_en, wr_row, wr_col, wr_char, refresh_req,
        input  init_done, busy, lcd_on, lcd_data, lcd_rs, lcd_rw, lcd_en
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_char, refresh_req,
        output init_done, busy, lcd_on, lcd_data, lcd_rs, lcd_rw, lcd_en
    );
endinterface

// File: rtl/lcd_text_engine.sv
// HD44780 text engine: power-up wait, init commands, then mirrors a ROWSxCOLS
// character buffer to the panel whenever it changes or a refresh is requested.
module lcd_text_engine #(
    parameter int unsigned COLS         = 16,
    parameter int unsigned ROWS         = 2,
    parameter int unsigned EN_CYCLES    = 12,
    parameter int unsigned DLY_CYCLES   = 262143,
    parameter int unsigned PWRUP_CYCLES = 750000
) (
    input  logic      clk,
    input  logic      rst,
    lcd_text_if.slave bus
);
    localparam int unsigned XFER  = 1 + EN_CYCLES + DLY_CYCLES;
    localparam int unsigned XW    = $clog2(XFER);
    localparam int unsigned PW    = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = $clog2(COLS + 1);
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [1:0] {PWRUP, INIT, IDLE, REFRESH} state_t;
    state_t state, state_nxt;

    logic [7:0]    buffer [CELLS];
    logic          dirty;
    logic [PW-1:0] pwr_cnt;
    logic [XW-1:0] xcnt;
    logic [1:0]    init_idx, init_idx_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          rs_q, rs_nxt, done_q;
    logic          load, xfer_last, pwr_last, wr_valid;
    logic [AW-1:0] wr_addr, rd_addr;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] row_cmd(input logic [RW-1:0] r);
        logic [7:0] base;
        case (32'(r))
            0:       base = 8'h00;
            1:       base = 8'h40;
            2:       base = 8'(COLS);
            default: base = 8'h40 + 8'(COLS);
        endcase
        return 8'h80 | base;
    endfunction

    assign wr_valid  = bus.wr_en && (32'(bus.wr_row) < ROWS) && (32'(bus.wr_col) < COLS);
    assign wr_addr   = AW'(32'(bus.wr_row) * COLS + 32'(bus.wr_col));
    assign rd_addr   = AW'(32'(row) * COLS + 32'(col));
    assign pwr_last  = (pwr_cnt == PW'(PWRUP_CYCLES - 1));
    assign xfer_last = (xcnt == XW'(XFER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PWRUP;
        else     state <= state_nxt;
    end

    // load marks the edge that starts a transfer's setup cycle; col counts
    // transfers already issued in the current row (0 = row command pending).
    always_comb begin
        state_nxt    = state;
        load         = 1'b0;
        init_idx_nxt = init_idx;
        row_nxt      = row;
        col_nxt      = col;
        data_nxt     = data_q;
        rs_nxt       = 1'b0;
        case (state)
            PWRUP: if (pwr_last) begin
                state_nxt    = INIT;
                load         = 1'b1;
                init_idx_nxt = '0;
                data_nxt     = init_cmd(2'd0);
            end
            INIT: if (xfer_last) begin
                if (init_idx == 2'd3) begin
                    state_nxt = IDLE;
                end else begin
                    load         = 1'b1;
                    init_idx_nxt = init_idx + 2'd1;
                    data_nxt     = init_cmd(init_idx + 2'd1);
                end
            end
            IDLE: if (dirty) begin
                state_nxt = REFRESH;
                load      = 1'b1;
                row_nxt   = '0;
                col_nxt   = '0;
                data_nxt  = row_cmd('0);
            end
            REFRESH: if (xfer_last) begin
                if (col == CW'(COLS)) begin
                    if (row == RW'(ROWS - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        load     = 1'b1;
                        row_nxt  = row + RW'(1);
                        col_nxt  = '0;
                        data_nxt = row_cmd(row + RW'(1));
                    end
                end else begin
                    load     = 1'b1;
                    col_nxt  = col + CW'(1);
                    rs_nxt   = 1'b1;
                    data_nxt = buffer[rd_addr];
                end
            end
            default: state_nxt = PWRUP;
        endcase
    end

    always_comb begin
        bus.busy   = (state != IDLE);
        bus.lcd_en = ((state == INIT) || (state == REFRESH)) &&
                     (xcnt != '0) && (32'(xcnt) <= EN_CYCLES);
    end

    assign bus.lcd_on    = 1'b1;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_data  = data_q;
    assign bus.lcd_rs    = rs_q;
    assign bus.init_done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr_cnt  <= '0;
            xcnt     <= '0;
            init_idx <= '0;
            row      <= '0;
            col      <= '0;
            data_q   <= '0;
            rs_q     <= 1'b0;
            done_q   <= 1'b0;
            dirty    <= 1'b1;
        end else begin
            if (state == PWRUP) pwr_cnt <= pwr_cnt + PW'(1);
            if (((state == INIT) || (state == REFRESH)) && !xfer_last) xcnt <= xcnt + XW'(1);
            else                                                       xcnt <= '0;
            init_idx <= init_idx_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            if (load) begin
                data_q <= data_nxt;
                rs_q   <= rs_nxt;
            end
            if ((state == INIT) && (state_nxt == IDLE)) done_q <= 1'b1;
            // IDLE consumes dirty, but a same-cycle write/request keeps it set
            dirty <= wr_valid | bus.refresh_req | (dirty & (state != IDLE));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CELLS; i++) buffer[i] <= 8'h20;
        end else if (wr_valid) begin
            buffer[wr_addr] <= bus.wr_char;
        end
    end
endmodule
